// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: req/ack data-bus transaction with byte-lane steering and load extension.
// Optional misaligned-access detection is enabled by defining LSU_ALIGN_CHK_EN.
module lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TO_W           = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  ls_size,
  input  logic        ls_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  output logic [31:0] ddata,
  output logic        ls_stall,
  output logic        ls_done,
  output logic        bus_err,
  output logic        misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic [1:0]      lat_size;
  logic [1:0]      lat_off;
  logic            lat_unsigned;
  logic [3:0]      be_nxt;
  logic [31:0]     wdata_nxt;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     load_val;
  logic            is_mis;

`ifdef LSU_ALIGN_CHK_EN
  assign is_mis = ((ls_size == 2'b01) && addr[0]) ||
                  (ls_size[1] && (addr[1:0] != 2'b00));
`else
  assign is_mis   = 1'b0;
  assign misalign = 1'b0;
`endif

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = st_data;
    case (ls_size)
      2'b00: begin
        be_nxt    = 4'b0001 << addr[1:0];
        wdata_nxt = {4{st_data[7:0]}};
      end
      2'b01: begin
        be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the offset/size captured at request time, not the live inputs.
  always_comb begin
    case (lat_off)
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = lat_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (lat_size)
      2'b00:   load_val = {{24{ld_byte[7] & ~lat_unsigned}}, ld_byte};
      2'b01:   load_val = {{16{ld_half[15] & ~lat_unsigned}}, ld_half};
      default: load_val = bus_rdata;
    endcase
  end

  always_comb begin
    case (state)
      IDLE:    ls_stall = mem_rd | mem_wr;
      REQ:     ls_stall = 1'b1;
      default: ls_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      to_cnt       <= '0;
      lat_size     <= '0;
      lat_off      <= '0;
      lat_unsigned <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_be       <= '0;
      bus_wdata    <= '0;
      ddata        <= '0;
      ls_done      <= 1'b0;
      bus_err      <= 1'b0;
`ifdef LSU_ALIGN_CHK_EN
      misalign     <= 1'b0;
`endif
    end else begin
      ls_done <= 1'b0;
      bus_err <= 1'b0;
`ifdef LSU_ALIGN_CHK_EN
      misalign <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (mem_rd || mem_wr) begin
            lat_size     <= ls_size;
            lat_off      <= addr[1:0];
            lat_unsigned <= ls_unsigned;
            if (is_mis) begin
              state   <= DONE;
              ls_done <= 1'b1;
`ifdef LSU_ALIGN_CHK_EN
              misalign <= 1'b1;
`endif
            end else begin
              state     <= REQ;
              to_cnt    <= '0;
              bus_req   <= 1'b1;
              bus_we    <= mem_wr;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= be_nxt;
              bus_wdata <= wdata_nxt;
            end
          end
        end
        REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            ls_done <= 1'b1;
            state   <= DONE;
            if (!bus_we) ddata <= load_val;
          end else if (to_cnt == TO_LAST) begin
            bus_req <= 1'b0;
            ls_done <= 1'b1;
            bus_err <= 1'b1;
            state   <= DONE;
            if (!bus_we) ddata <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed scoreboard bench for lsu_bus_ctrl: per-cycle bus/status checks against a byte-level reference model.
module tb_lsu_bus_ctrl;

  localparam int TIMEOUT = 16;
`ifdef LSU_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [1:0]  ls_size = 2'b00;
  logic        ls_unsigned = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] st_data = '0;
  logic [31:0] ddata;
  logic        ls_stall, ls_done, bus_err, misalign;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  always #5 clk = ~clk;

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ls_size(ls_size), .ls_unsigned(ls_unsigned), .addr(addr), .st_data(st_data),
    .ddata(ddata), .ls_stall(ls_stall), .ls_done(ls_done), .bus_err(bus_err),
    .misalign(misalign), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ddata;
    logic        err;
    logic        mis;
    int          req_cyc;
    int          done_cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] model_ddata = '0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic uns, input int unsigned base,
                                             input int unsigned nb, input logic [31:0] rd);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < nb; i++) r[8*i +: 8] = rd[8*(base+i) +: 8];
    if (!uns && nb < 4 && r[8*nb-1])
      for (int unsigned i = 8*nb; i < 32; i++) r[i] = 1'b1;
    return r;
  endfunction

  // ack_at: cycle (request cycle = 0) in which bus_ack is driven high; <1 means never.
  task automatic access(input logic wr, input logic rd, input logic [1:0] size, input logic uns,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                        input int ack_at);
    exp_t        e;
    exp_t        h;
    int unsigned nb;
    int unsigned base;
    logic        mis;
    nb   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    base = 32'(a[1:0]);
    base = (base / nb) * nb;
    for (int unsigned i = 0; i < 4; i++) begin
      e.be[i]          = (i >= base) && (i < base + nb);
      e.wdata[8*i +: 8] = sd[8*(i % nb) +: 8];
    end
    mis    = ALIGN && (((size == 2'b01) && a[0]) || (size[1] && (a[1:0] != 2'b00)));
    e.we   = wr;
    e.addr = {a[31:2], 2'b00};
    e.mis  = mis;
    if (mis) begin
      e.req_cyc = 0; e.done_cyc = 1; e.err = 1'b0; e.ddata = model_ddata;
    end else if (ack_at < 1 || ack_at > TIMEOUT) begin
      e.req_cyc = TIMEOUT; e.done_cyc = TIMEOUT + 1; e.err = 1'b1;
      e.ddata = wr ? model_ddata : 32'h0;
    end else begin
      e.req_cyc = ack_at; e.done_cyc = ack_at + 1; e.err = 1'b0;
      e.ddata = wr ? model_ddata : model_load(uns, base, nb, rdat);
    end
    model_ddata = e.ddata;
    sb.push_back(e);

    @(posedge clk); #1;
    mem_wr = wr; mem_rd = rd; ls_size = size; ls_unsigned = uns; addr = a; st_data = sd;
    for (int cyc = 0; cyc <= e.done_cyc; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      bus_ack   = (cyc == ack_at);
      bus_rdata = (cyc == ack_at) ? rdat : 32'hDEAD_BEEF;
      @(negedge clk);
      h = sb[0];
      chk("bus_req", 80'(bus_req), 80'(cyc >= 1 && cyc <= h.req_cyc));
      if (bus_req)
        chk("bus_fields", {bus_we, bus_addr, bus_be, h.we ? bus_wdata : 32'h0},
                          {h.we, h.addr, h.be, h.we ? h.wdata : 32'h0});
      if (cyc == h.done_cyc) begin
        chk("status_done", {ls_stall, ls_done, bus_err, misalign}, {1'b0, 1'b1, h.err, h.mis});
        chk("ddata", ddata, h.ddata);
        void'(sb.pop_front());
      end else begin
        chk("status_busy", {ls_stall, ls_done, bus_err, misalign}, 4'b1000);
      end
    end
    @(posedge clk); #1;
    mem_rd = 1'b0; mem_wr = 1'b0; bus_ack = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_bus", {bus_req, bus_we, bus_addr, bus_be, bus_wdata}, '0);
    chk("rst_out", {ddata, ls_done, bus_err, misalign, ls_stall}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Word load, ack two cycles after bus_req rises
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_1004, 32'h0, 32'h1234_5678, 3);
    chk("plan_word_ddata", ddata, 32'h1234_5678);
    // Byte load from lane 3, signed then unsigned, minimum latency
    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0003, 32'h0, 32'h80FF_1234, 1);
    chk("plan_sbyte", ddata, 32'hFFFF_FF80);
    access(1'b0, 1'b1, 2'b00, 1'b1, 32'h0000_0003, 32'h0, 32'h80FF_1234, 1);
    chk("plan_ubyte", ddata, 32'h0000_0080);
    // Half store to upper half; ddata must hold
    access(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0000_ABCD, 32'h0, 2);
    chk("plan_store_hold", ddata, 32'h0000_0080);

    // bus_ack while idle must be ignored
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ack", {bus_req, ls_done, ls_stall, bus_err}, 4'b0000);
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
    chk("idle_ddata", ddata, model_ddata);

    // Load that never sees an ack
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_2000, 32'h0, 32'hFFFF_FFFF, -1);
    chk("plan_timeout_ddata", ddata, 32'h0);
    // Word load at non-word-aligned address
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0002, 32'h0, 32'hCAFE_F00D, 1);

    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0, 32'h9ABC_1234, 1);
    access(1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0020, 32'h0, 32'h1234_8001, 2);
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0031, 32'h0000_00A5, 32'h0, 1);
    access(1'b1, 1'b1, 2'b11, 1'b0, 32'h0000_0044, 32'h1122_3344, 32'h7777_7777, 1);
    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h0, 32'h0000_7F00, 3);
    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0013, 32'h0, 32'hF00D_0000, 1);
    // Ack on the last permitted REQ cycle completes normally
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0050, 32'h0, 32'h0BAD_CAFE, TIMEOUT);
    // Ack arriving one cycle late lands in DONE and is ignored
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0054, 32'h0102_0304, 32'h0, TIMEOUT + 1);
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0058, 32'h0, 32'h1357_9BDF, 1);

    // Reset during REQ
    @(posedge clk); #1;
    mem_rd = 1'b1; ls_size = 2'b10; addr = 32'h0000_0040; ls_unsigned = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_pre_req", 80'(bus_req), 80'(1'b1));
    #2; rst_n = 1'b0; #1;
    chk("rst_mid_req", 80'(bus_req), 80'(1'b0));
    chk("rst_mid_ddata", ddata, 32'h0);
    chk("rst_mid_pulses", {ls_done, bus_err, misalign, bus_be, bus_addr}, '0);
    mem_rd = 1'b0;
    model_ddata = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_quiet", {bus_req, ls_done, bus_err}, 3'b000);
      @(posedge clk); #1;
    end
    access(1'b0, 1'b1, 2'b00, 1'b1, 32'h0000_0062, 32'h0, 32'h00C3_0000, 2);
    chk("post_rst_load", ddata, 32'h0000_00C3);

    chk("sb_empty", 80'(sb.size()), 80'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
- Load/store unit between the execute stage and the data bus.
- Takes the ALU-computed address and store data, then runs a req/ack bus transaction with byte-lane steering.
- Produces the aligned, extended load word `ddata` consumed by the write-back select.
- Stalls the CPU while a transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in REQ waiting for bus_ack before abort.
- TO_W, 5: timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_rd  in  1  CU load request for the current instruction.
- mem_wr  in  1  CU store request for the current instruction.
- ls_size  in  2  00 byte, 01 half, 10/11 word.
- ls_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
- addr  in  32  byte address (ALU result).
- st_data  in  32  store data, right-justified.
- ddata  out  32  load result to write-back select.
- ls_stall  out  1  1 = hold PC/instruction.
- ls_done  out  1  one-cycle pulse when an access retires.
- bus_err  out  1  one-cycle pulse with ls_done on timeout.
- misalign  out  1  one-cycle pulse with ls_done on misaligned access (optional feature).
- bus_req  out  1  bus request, held until ack.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  read data, valid with bus_ack.
- bus_ack  in  1  transfer complete.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - bus_req, bus_we, ls_done, bus_err, misalign = 0.
  - bus_addr, bus_be, bus_wdata = 0; ddata = 0; timeout counter = 0.
  - Reset mid-transaction drops bus_req immediately; no completion pulse.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If mem_wr or mem_rd is high, latch addr/size/unsigned/st_data and go to REQ.
  - If both are high, the write wins.
  - ls_stall = mem_rd|mem_wr (combinational).
  - bus_ack in IDLE is ignored.
- REQ:
  - bus_req=1 with stable bus_we/bus_addr/bus_be/bus_wdata; ls_stall=1; counter increments each cycle.
  - On bus_ack: loads capture bus_rdata into ddata; go to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 without ack: drop bus_req, set ddata=0 for loads, go to DONE with the error flag set.
- DONE:
  - ls_done=1, ls_stall=0, bus_req=0; bus_err=1 if timed out.
  - Next state is IDLE unconditionally; the request seen in DONE belongs to the retiring instruction and is not re-issued.
- Latency:
  - Request seen in cycle 0; bus_req high from cycle 1; ack in cycle k gives ls_done in cycle k+1.
  - Minimum 3 cycles per memory instruction (ack in cycle 1).
- Byte lanes (little-endian, o = addr[1:0]):
  - byte: be = 4'b0001 << o; wdata = {4{st_data[7:0]}}.
  - half: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{st_data[15:0]}}.
  - word: be = 4'b1111; wdata = st_data.
  - Reads drive the same bus_be as writes.
- Load extract:
  - byte = rdata[8*o +: 8]; half = rdata[16*addr[1] +: 16].
  - Extend to 32 bits per ls_unsigned; word loads are passed through.
- ddata holds its value across stores, idle cycles and errors, except that a timed-out load writes 0.

Optional Feature:
- Macro: LSU_ALIGN_CHK_EN.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, is misaligned.
  - Misaligned access goes IDLE→DONE directly with no bus transaction.
  - misalign=1 and ls_done=1 in DONE; ddata unchanged.
- Undefined:
  - The misalign output is tied to 0.
  - Half accesses ignore addr[0]; word accesses ignore addr[1:0]; the access proceeds normally.

Test Plan:
- Word load at addr 0x0000_1004, bus_ack 2 cycles after bus_req, rdata 0x1234_5678 → bus_addr 0x0000_1004, be 1111, ddata 0x1234_5678, ls_done in cycle 4, ls_stall high in cycles 0–3.
- Signed byte load at addr 0x0000_0003, rdata 0x80FF_1234 → be 1000, ddata 0xFFFF_FF80; the same load with ls_unsigned=1 → 0x0000_0080.
- Half store at addr 0x0000_0012, st_data 0x0000_ABCD → bus_we 1, be 1100, bus_wdata 0xABCD_ABCD, bus_addr 0x0000_0010; ddata unchanged.
- Load with bus_ack never asserted, TIMEOUT_CYCLES=16 → bus_req high for exactly 16 cycles, then ls_done+bus_err pulse, ddata 0x0000_0000, FSM back to IDLE.
- Word load at addr 0x0000_0002 → with LSU_ALIGN_CHK_EN: bus_req never asserted, misalign+ls_done in cycle 1. Without it: bus_addr 0x0000_0000, be 1111, normal completion.
- rst_n pulled low during REQ → bus_req 0 immediately (same cycle), ddata 0. After release, a new mem_rd starts a fresh transaction with no stray ls_done.
